// File: rtl/gray_counter_conv.sv
// gray_counter_conv: WIDTH-bit up/down counter with a registered Gray copy,
// binary or Gray parallel load, and wrap / saturate event flags.
module gray_counter_conv #(
   parameter int WIDTH = 4,
   parameter bit WRAP  = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic             load_is_gray,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] binary_out,
   output logic [WIDTH-1:0] gray_out,
   output logic             wrap,
   output logic             sat
);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] gray_q, gray_d;
   logic [WIDTH-1:0] load_bin;
   logic             wrap_q, wrap_d;
   logic             sat_q, sat_d;
   logic             at_lim;

   // Each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      load_bin = '0;
      for (int i = 0; i < WIDTH; i++) begin
         load_bin[i] = ^(load_val >> i);
      end
   end

   assign at_lim = up ? (&cnt_q) : ~(|cnt_q);

   always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      sat_d  = 1'b0;
      if (load) begin
         cnt_d = load_is_gray ? load_bin : load_val;
      end else if (en) begin
         if (at_lim && !WRAP) begin
            sat_d = 1'b1;
         end else begin
            cnt_d  = up ? cnt_q + 1'b1 : cnt_q - 1'b1;
            wrap_d = at_lim;
         end
      end
   end

   assign gray_d = cnt_d ^ (cnt_d >> 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         gray_q <= '0;
         wrap_q <= 1'b0;
         sat_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         gray_q <= gray_d;
         wrap_q <= wrap_d;
         sat_q  <= sat_d;
      end
   end

   assign binary_out = cnt_q;
   assign gray_out   = gray_q;
   assign wrap       = wrap_q;
   assign sat        = sat_q;

endmodule
